// File: rtl/mbox_pf_seq_if.sv
// Error-source / EBOX side signal bundle for the page-fail sequencer.
interface mbox_pf_seq_if #(
    parameter int ADR_W = 9
);
    logic             eboxCyc;
    logic             eboxT0;
    logic             mboxRespIn;
    logic             pfEboxHandle;
    logic [6:0]       pfCode;
    logic             cshAdrParErr;
    logic             mbParErr;
    logic             adrParErr;
    logic             nxmErr;
    logic             sbusErr;
    logic [ADR_W-1:0] gateVma;
    logic [4:0]       errClr;
    logic             errIntEn;
    logic             pageFailHold;
    logic             eboxRetryReq;
    logic [10:0]      pfDisp;
    logic [4:0]       errSticky;
    logic [ADR_W-1:0] errFirstAdr;
    logic [3:0]       errFirstCls;
    logic             errOverflow;
    logic             aprErrInt;

    modport master (
        output eboxCyc, eboxT0, mboxRespIn, pfEboxHandle, pfCode,
        output cshAdrParErr, mbParErr, adrParErr, nxmErr, sbusErr,
        output gateVma, errClr, errIntEn,
        input  pageFailHold, eboxRetryReq, pfDisp, errSticky,
        input  errFirstAdr, errFirstCls, errOverflow, aprErrInt
    );

    modport slave (
        input  eboxCyc, eboxT0, mboxRespIn, pfEboxHandle, pfCode,
        input  cshAdrParErr, mbParErr, adrParErr, nxmErr, sbusErr,
        input  gateVma, errClr, errIntEn,
        output pageFailHold, eboxRetryReq, pfDisp, errSticky,
        output errFirstAdr, errFirstCls, errOverflow, aprErrInt
    );
endinterface

// File: rtl/mbox_pf_seq.sv
// Page-fail / error sequencer between MBOX/CSH error sources and the EBOX.
// Sticky error capture plus hold / bounded-retry control for EBOX cycles.
module mbox_pf_seq #(
    parameter int MAX_RETRY = 3,
    parameter int ADR_W     = 9
) (
    input logic          clk,
    input logic          resetN,
    mbox_pf_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RETRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] CLS_PAGE   = 4'h1;
    localparam logic [3:0] CLS_NXM    = 4'h2;
    localparam logic [3:0] CLS_MBPAR  = 4'h3;
    localparam logic [3:0] CLS_ADRPAR = 4'h4;
    localparam logic [3:0] CLS_SBUS   = 4'h5;
    localparam logic [3:0] CLS_EXH    = 4'h6;
    localparam logic [3:0] CLS_CSHPAR = 4'h7;
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

    state_t           state;
    logic [3:0]       retry_cnt;
    logic             hold;
    logic             retry_req;
    logic [10:0]      disp;
    logic [4:0]       sticky;
    logic [ADR_W-1:0] first_adr;
    logic [3:0]       first_cls;
    logic             overflow;

    logic [4:0]  err;
    logic        fatal;
    logic        any_err;
    logic        any_strobe;
    logic        csh_only;
    logic        take_pf;
    logic [3:0]  fault_cls;
    logic [10:0] fault_disp;
    logic [3:0]  cap_cls;
    logic [4:0]  sticky_nxt;

    assign err = {bus.nxmErr, bus.mbParErr, bus.adrParErr,
                  bus.sbusErr, bus.cshAdrParErr};
    assign fatal      = |err[4:1];
    assign any_err    = |err;
    assign any_strobe = any_err | bus.pfEboxHandle;
    assign csh_only   = bus.cshAdrParErr & ~fatal & ~bus.pfEboxHandle;
    assign take_pf    = bus.eboxCyc & (fatal | bus.pfEboxHandle);
    assign sticky_nxt = (sticky & ~bus.errClr) | err;

    always_comb begin
        fault_cls = CLS_PAGE;
        priority case (1'b1)
            bus.nxmErr:    fault_cls = CLS_NXM;
            bus.mbParErr:  fault_cls = CLS_MBPAR;
            bus.adrParErr: fault_cls = CLS_ADRPAR;
            bus.sbusErr:   fault_cls = CLS_SBUS;
            default:       fault_cls = CLS_PAGE;
        endcase
    end

    // Only a pure PAG failure carries detail; hardware errors report 0.
    assign fault_disp = (fault_cls == CLS_PAGE) ?
                        {CLS_PAGE, bus.pfCode} : {fault_cls, 7'd0};
    assign cap_cls    = fatal ? fault_cls : CLS_CSHPAR;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            retry_cnt <= 4'd0;
            hold      <= 1'b0;
            retry_req <= 1'b0;
            disp      <= 11'd0;
            sticky    <= 5'd0;
            first_adr <= '0;
            first_cls <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            sticky <= sticky_nxt;
            if (sticky == 5'd0 && any_err) begin
                first_adr <= bus.gateVma;
                first_cls <= cap_cls;
            end
            if (sticky_nxt == 5'd0)
                overflow <= 1'b0;
            else if (sticky != 5'd0 && any_err)
                overflow <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (take_pf) begin
                        state     <= HOLD;
                        hold      <= 1'b1;
                        disp      <= fault_disp;
                        retry_cnt <= 4'd0;
                    end else if (bus.eboxCyc && csh_only) begin
                        if (retry_cnt < RETRY_MAX) begin
                            state     <= RETRY;
                            retry_req <= 1'b1;
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            state     <= HOLD;
                            hold      <= 1'b1;
                            disp      <= {CLS_EXH, 3'b000, retry_cnt};
                            retry_cnt <= 4'd0;
                        end
                    end else if (bus.mboxRespIn && !any_strobe) begin
                        retry_cnt <= 4'd0;
                    end
                end
                RETRY: begin
                    // A real fault outranks the pending retry ack.
                    if (take_pf) begin
                        state     <= HOLD;
                        retry_req <= 1'b0;
                        hold      <= 1'b1;
                        disp      <= fault_disp;
                        retry_cnt <= 4'd0;
                    end else if (bus.eboxT0) begin
                        state     <= IDLE;
                        retry_req <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.eboxT0) begin
                        state <= IDLE;
                        hold  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    hold      <= 1'b0;
                    retry_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pageFailHold = hold;
    assign bus.eboxRetryReq = retry_req;
    assign bus.pfDisp       = disp;
    assign bus.errSticky    = sticky;
    assign bus.errFirstAdr  = first_adr;
    assign bus.errFirstCls  = first_cls;
    assign bus.errOverflow  = overflow;
    assign bus.aprErrInt    = bus.errIntEn & (|sticky);
endmodule

// File: tb/tb_mbox_pf_seq.sv
// Randomized bench for mbox_pf_seq against a behavioural model.
module tb_mbox_pf_seq;
    localparam int MAXR = 3;
    localparam int AW   = 9;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int checks = 0;
    int failures = 0;

    mbox_pf_seq_if #(.ADR_W(AW)) bus ();

    mbox_pf_seq #(.MAX_RETRY(MAXR), .ADR_W(AW)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // model: expected outputs after the upcoming rising edge
    bit          m_hold;
    bit          m_req;
    int          m_cnt;
    logic [10:0] m_disp;
    logic [4:0]  m_sticky;
    logic [8:0]  m_adr;
    logic [3:0]  m_fcls;
    bit          m_ovf;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_req = 0; m_cnt = 0; m_disp = '0;
        m_sticky = '0; m_adr = '0; m_fcls = '0; m_ovf = 0;
    endtask

    function automatic logic [3:0] fault_class();
        if (bus.nxmErr) return 4'h2;
        if (bus.mbParErr) return 4'h3;
        if (bus.adrParErr) return 4'h4;
        if (bus.sbusErr) return 4'h5;
        return 4'h1;
    endfunction

    task automatic model_step();
        logic [4:0] e;
        logic [4:0] nxt;
        logic [3:0] c;
        bit fatal, pf, ebox, csh_only, any_err;
        e = {bus.nxmErr, bus.mbParErr, bus.adrParErr, bus.sbusErr,
             bus.cshAdrParErr};
        fatal = (e[4:1] != 0);
        any_err = (e != 0);
        pf = bus.pfEboxHandle;
        ebox = bus.eboxCyc;
        csh_only = bus.cshAdrParErr && !fatal && !pf;
        nxt = (m_sticky & ~bus.errClr) | e;
        if (m_sticky == 0 && any_err) begin
            m_adr = bus.gateVma;
            m_fcls = fatal ? fault_class() : 4'h7;
        end
        if (nxt == 0) m_ovf = 0;
        else if (m_sticky != 0 && any_err) m_ovf = 1;
        m_sticky = nxt;
        if (m_hold) begin
            if (bus.eboxT0) m_hold = 0;
        end else if (ebox && (fatal || pf)) begin
            c = fault_class();
            m_req = 0;
            m_hold = 1;
            m_cnt = 0;
            m_disp = {c, (c == 4'h1) ? bus.pfCode : 7'd0};
        end else if (m_req) begin
            if (bus.eboxT0) m_req = 0;
        end else if (ebox && csh_only) begin
            if (m_cnt < MAXR) begin
                m_cnt++;
                m_req = 1;
            end else begin
                m_hold = 1;
                m_disp = {4'h6, 7'(m_cnt)};
                m_cnt = 0;
            end
        end else if (bus.mboxRespIn && !any_err && !pf) begin
            m_cnt = 0;
        end
    endtask

    task automatic check_outputs(string p);
        chk({p, "_hold"}, bus.pageFailHold, m_hold);
        chk({p, "_req"}, bus.eboxRetryReq, m_req);
        chk({p, "_disp"}, bus.pfDisp, m_disp);
        chk({p, "_sticky"}, bus.errSticky, m_sticky);
        chk({p, "_fadr"}, bus.errFirstAdr, m_adr);
        chk({p, "_fcls"}, bus.errFirstCls, m_fcls);
        chk({p, "_ovf"}, bus.errOverflow, m_ovf);
        chk({p, "_int"}, bus.aprErrInt,
            32'(bus.errIntEn && (m_sticky != 0)));
        chk({p, "_excl"}, bus.pageFailHold & bus.eboxRetryReq, 0);
    endtask

    task automatic zero_in();
        bus.eboxCyc = 0; bus.eboxT0 = 0; bus.mboxRespIn = 0;
        bus.pfEboxHandle = 0; bus.pfCode = '0; bus.cshAdrParErr = 0;
        bus.mbParErr = 0; bus.adrParErr = 0; bus.nxmErr = 0;
        bus.sbusErr = 0; bus.gateVma = 9'($urandom);
        bus.errClr = '0; bus.errIntEn = 1;
    endtask

    task automatic tick(string p);
        model_step();
        @(negedge clk);
        check_outputs(p);
        zero_in();
    endtask

    // asserts reset between edges and checks it acts without a clock
    task automatic async_reset(string p);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        chk({p, "_async_hold"}, bus.pageFailHold, 0);
        check_outputs({p, "_rst"});
        @(negedge clk);
        resetN = 1'b1;
        zero_in();
    endtask

    task automatic rand_in();
        bus.eboxCyc = ($urandom_range(0, 3) != 0);
        bus.eboxT0 = ($urandom_range(0, 2) == 0);
        bus.mboxRespIn = ($urandom_range(0, 3) == 0);
        bus.pfEboxHandle = ($urandom_range(0, 11) == 0);
        bus.pfCode = 7'($urandom);
        bus.cshAdrParErr = ($urandom_range(0, 4) == 0);
        bus.mbParErr = ($urandom_range(0, 19) == 0);
        bus.adrParErr = ($urandom_range(0, 19) == 0);
        bus.nxmErr = ($urandom_range(0, 19) == 0);
        bus.sbusErr = ($urandom_range(0, 19) == 0);
        bus.gateVma = 9'($urandom);
        bus.errClr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
        bus.errIntEn = 1'($urandom);
    endtask

    initial begin
        model_reset();
        zero_in();
        @(negedge clk);
        check_outputs("reset");
        resetN = 1'b1;
        @(negedge clk);
        check_outputs("post_reset");

        // page fail from PAG, then ack
        bus.eboxCyc = 1; bus.pfEboxHandle = 1; bus.pfCode = 7'o23;
        tick("t1a");
        chk("t1_hold", bus.pageFailHold, 1);
        chk("t1_disp", bus.pfDisp, 11'h093);
        bus.eboxCyc = 1;
        tick("t1b");
        bus.eboxT0 = 1;
        tick("t1c");
        chk("t1_hold_drop", bus.pageFailHold, 0);
        chk("t1_disp_kept", bus.pfDisp, 11'h093);

        // simultaneous NXM and SBUS
        bus.eboxCyc = 1; bus.nxmErr = 1; bus.sbusErr = 1;
        tick("t2a");
        chk("t2_cls", bus.pfDisp[10:7], 4'h2);
        chk("t2_sticky", bus.errSticky, 5'b10010);
        chk("t2_fcls", bus.errFirstCls, 4'h2);
        bus.eboxT0 = 1;
        tick("t2b");
        bus.errClr = 5'h1F;
        tick("t2c");

        // retry exhaustion
        for (int i = 0; i < 4; i++) begin
            bus.eboxCyc = 1; bus.cshAdrParErr = 1;
            tick("t3csh");
            if (i < 3) begin
                chk("t3_req", bus.eboxRetryReq, 1);
                bus.eboxT0 = 1;
                tick("t3ack");
            end
        end
        chk("t3_hold", bus.pageFailHold, 1);
        chk("t3_disp", bus.pfDisp, 11'h303);
        bus.eboxT0 = 1;
        tick("t3b");
        bus.errClr = 5'h1F;
        tick("t3c");

        // sticky-only errors, overflow, clear
        bus.sbusErr = 1;
        tick("t4a");
        chk("t4_sbus", bus.errSticky[1], 1);
        chk("t4_nohold", bus.pageFailHold, 0);
        bus.mbParErr = 1;
        tick("t4b");
        chk("t4_ovf", bus.errOverflow, 1);
        chk("t4_int", bus.aprErrInt, 1);
        bus.errClr = 5'h1F;
        tick("t4c");
        chk("t4_clr", bus.errSticky, 0);
        chk("t4_ovf_clr", bus.errOverflow, 0);

        // fatal pre-empts a retry
        bus.eboxCyc = 1; bus.cshAdrParErr = 1;
        tick("t6a");
        bus.eboxCyc = 1; bus.mbParErr = 1;
        tick("t6b");
        chk("t6_req", bus.eboxRetryReq, 0);
        chk("t6_hold", bus.pageFailHold, 1);
        chk("t6_cls", bus.pfDisp[10:7], 4'h3);
        bus.eboxT0 = 1;
        tick("t6c");

        // reset in HOLD, and retry count cleared by reset
        bus.eboxCyc = 1; bus.pfEboxHandle = 1; bus.pfCode = 7'h55;
        tick("t5a");
        async_reset("t5");
        for (int i = 0; i < 2; i++) begin
            bus.eboxCyc = 1; bus.cshAdrParErr = 1;
            tick("t5r");
            bus.eboxT0 = 1;
            tick("t5ack");
        end
        async_reset("t5b");
        for (int i = 0; i < 3; i++) begin
            bus.eboxCyc = 1; bus.cshAdrParErr = 1;
            tick("t5c");
            chk("t5_cnt_reset", bus.eboxRetryReq, 1);
            bus.eboxT0 = 1;
            tick("t5cack");
        end

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rand_in();
            if ($urandom_range(0, 299) == 0) async_reset("rnd");
            else tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
